// File: rtl/spi_master.sv
// SPI mode-0 initiator (CPOL=0, CPHA=0, MSB first) with a start/busy/done handshake.
// Every output is registered. MISO is passed through a two-flop synchronizer before it is sampled.
module spi_master #(
  parameter int WIDTH  = 32,
  parameter int CLKDIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  output logic             SCLK,
  output logic             MOSI,
  input  logic             MISO,
  output logic             SEL_
);

  localparam int DW = $clog2(CLKDIV);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
  localparam logic [BW-1:0] BITS     = BW'(WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOW,
    HIGH,
    HOLD,
    GAP
  } state_t;

  state_t           state;
  logic [DW-1:0]    div;
  logic [BW-1:0]    bitcnt;
  logic [WIDTH-2:0] tx_sh;   // MSB goes out directly on MOSI, so it is not stored here
  logic [WIDTH-1:0] rx_sh;
  logic             miso_s1, miso_s2;
  logic             last;

  assign last = (div == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miso_s1 <= 1'b0;
      miso_s2 <= 1'b0;
    end else begin
      miso_s1 <= MISO;
      miso_s2 <= miso_s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      div     <= '0;
      bitcnt  <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rx_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      SCLK    <= 1'b0;
      MOSI    <= 1'b0;
      SEL_    <= 1'b1;
    end else begin
      done <= 1'b0;
      // Every state other than IDLE lasts exactly CLKDIV cycles.
      if (state != IDLE) div <= last ? '0 : div + 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            tx_sh  <= tx_data[WIDTH-2:0];
            bitcnt <= BITS;
            SEL_   <= 1'b0;
            busy   <= 1'b1;
            MOSI   <= tx_data[WIDTH-1];
            div    <= '0;
            state  <= SETUP;
          end
        end
        SETUP: begin
          if (last) state <= LOW;
        end
        LOW: begin
          if (last) begin
            rx_sh <= {rx_sh[WIDTH-2:0], miso_s2};
            SCLK  <= 1'b1;
            state <= HIGH;
          end
        end
        HIGH: begin
          if (last) begin
            SCLK   <= 1'b0;
            bitcnt <= bitcnt - 1'b1;
            if (bitcnt == BW'(1)) begin
              state <= HOLD;
            end else begin
              MOSI  <= tx_sh[WIDTH-2];
              tx_sh <= tx_sh << 1;
              state <= LOW;
            end
          end
        end
        HOLD: begin
          if (last) begin
            SEL_    <= 1'b1;
            rx_data <= rx_sh;
            done    <= 1'b1;
            state   <= GAP;
          end
        end
        GAP: begin
          if (last) begin
            busy  <= 1'b0;
            MOSI  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: three instances (W8/C4, W32/C4, W2/C6), shared slave model.
module tb_spi_master;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, miso;
  logic [1:0]  dsel;
  logic        start8, start32, start2;
  logic [7:0]  tx8;
  logic [31:0] tx32;
  logic [1:0]  tx2;
  logic        busy8, done8, sclk8, mosi8, sel8;
  logic        busy32, done32, sclk32, mosi32, sel32;
  logic        busy2, done2, sclk2, mosi2, sel2;
  logic [7:0]  rx8;
  logic [31:0] rx32;
  logic [1:0]  rx2;

  spi_master #(.WIDTH(8), .CLKDIV(4)) u8 (
    .clk(clk), .rst(rst), .start(start8), .tx_data(tx8), .busy(busy8), .done(done8),
    .rx_data(rx8), .SCLK(sclk8), .MOSI(mosi8), .MISO(miso), .SEL_(sel8));
  spi_master #(.WIDTH(32), .CLKDIV(4)) u32 (
    .clk(clk), .rst(rst), .start(start32), .tx_data(tx32), .busy(busy32), .done(done32),
    .rx_data(rx32), .SCLK(sclk32), .MOSI(mosi32), .MISO(miso), .SEL_(sel32));
  spi_master #(.WIDTH(2), .CLKDIV(6)) u2 (
    .clk(clk), .rst(rst), .start(start2), .tx_data(tx2), .busy(busy2), .done(done2),
    .rx_data(rx2), .SCLK(sclk2), .MOSI(mosi2), .MISO(miso), .SEL_(sel2));

  logic        o_busy, o_done, o_sclk, o_mosi, o_sel;
  logic [31:0] o_rx;
  assign o_busy = (dsel == 2'd0) ? busy8 : (dsel == 2'd1) ? busy32 : busy2;
  assign o_done = (dsel == 2'd0) ? done8 : (dsel == 2'd1) ? done32 : done2;
  assign o_sclk = (dsel == 2'd0) ? sclk8 : (dsel == 2'd1) ? sclk32 : sclk2;
  assign o_mosi = (dsel == 2'd0) ? mosi8 : (dsel == 2'd1) ? mosi32 : mosi2;
  assign o_sel  = (dsel == 2'd0) ? sel8  : (dsel == 2'd1) ? sel32  : sel2;
  assign o_rx   = (dsel == 2'd0) ? {24'd0, rx8} : (dsel == 2'd1) ? rx32 : {30'd0, rx2};

  int tests = 0;
  int fails = 0;

  int          rise_t [64];
  logic        mosi_b [64];
  int          nrise, ndone, nsel_fall, nsel_rise, busy_fall_t;
  int          done_t [4];
  logic [31:0] done_rx [4];
  int          sel_fall_t [4];
  int          sel_rise_t [4];
  logic [31:0] slv_got [4];

  task automatic drive(input logic s, input logic [31:0] d);
    start8  = s && (dsel == 2'd0);
    start32 = s && (dsel == 2'd1);
    start2  = s && (dsel == 2'd2);
    tx8  = d[7:0];
    tx32 = d;
    tx2  = d[1:0];
  endtask

  // Runs one window starting at edge 0; the slave shifts MISO on SEL_ fall and SCLK fall.
  task automatic xfer(input int w, input logic [31:0] tx_a, input logic [31:0] tx_b,
                      input logic [31:0] sw0, input logic [31:0] sw1,
                      input int hold_until, input int poke_t, input int max_t);
    logic [31:0] sh, srx;
    logic p_sclk, p_sel, p_busy;
    nrise = 0; ndone = 0; nsel_fall = 0; nsel_rise = 0; busy_fall_t = -1;
    sh = '0; srx = '0;
    p_sclk = 1'b0; p_sel = 1'b1; p_busy = 1'b0;
    @(negedge clk);
    drive(1'b1, tx_a);
    for (int t = 0; t < max_t; t++) begin
      @(posedge clk);
      #1;
      if (p_sel && !o_sel) begin
        sh = (nsel_fall == 0) ? sw0 : sw1;
        srx = '0;
        miso = sh[w-1];
        if (nsel_fall < 4) sel_fall_t[nsel_fall] = t;
        nsel_fall++;
      end
      if (!p_sclk && o_sclk) begin
        if (nrise < 64) begin
          rise_t[nrise] = t;
          mosi_b[nrise] = o_mosi;
        end
        nrise++;
        srx = {srx[30:0], o_mosi};
      end
      if (p_sclk && !o_sclk) begin
        sh = sh << 1;
        miso = sh[w-1];
      end
      if (!p_sel && o_sel) begin
        if (nsel_rise < 4) begin
          sel_rise_t[nsel_rise] = t;
          slv_got[nsel_rise] = srx;
        end
        nsel_rise++;
      end
      if (o_done) begin
        if (ndone < 4) begin
          done_t[ndone] = t;
          done_rx[ndone] = o_rx;
        end
        ndone++;
      end
      if (p_busy && !o_busy) busy_fall_t = t;
      p_sclk = o_sclk; p_sel = o_sel; p_busy = o_busy;
      drive((t < hold_until) || (t == poke_t), (t == 0) ? tx_b : (t > 0 ? tx_b : tx_a));
    end
    drive(1'b0, tx_b);
  endtask

  task automatic test_reset();
    int nd;
    dsel = 2'd0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++; if (sel8 !== 1'b1) begin fails++; $display("FAIL idle_rst_sel: got %b want 1", sel8); end
    tests++; if (sclk8 !== 1'b0) begin fails++; $display("FAIL idle_rst_sclk: got %b want 0", sclk8); end
    tests++; if (rx8 !== 8'h00) begin fails++; $display("FAIL idle_rst_rx: got %h want 00", rx8); end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 32'hA5);
    @(posedge clk);
    #1;
    drive(1'b0, 32'hA5);
    repeat (30) @(posedge clk);
    #1;
    tests++; if (sel8 !== 1'b0) begin fails++; $display("FAIL mid_sel_low: got %b want 0", sel8); end
    #2;
    rst = 1'b1;
    #1;
    tests++; if (sel8 !== 1'b1) begin fails++; $display("FAIL abort_sel: got %b want 1", sel8); end
    tests++; if (sclk8 !== 1'b0) begin fails++; $display("FAIL abort_sclk: got %b want 0", sclk8); end
    tests++; if (mosi8 !== 1'b0) begin fails++; $display("FAIL abort_mosi: got %b want 0", mosi8); end
    tests++; if (busy8 !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b want 0", busy8); end
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done8 || busy8) nd++;
    end
    tests++; if (nd !== 0) begin fails++; $display("FAIL abort_no_done: got %0d busy/done cycles want 0", nd); end
  endtask

  task automatic test_basic8();
    logic [7:0] exp_bits;
    exp_bits = 8'hA5;
    dsel = 2'd0;
    xfer(8, 32'hA5, 32'hA5, 32'h3C, 32'h3C, 0, -1, 90);
    tests++; if (sel_fall_t[0] !== 0 && sel_fall_t[0] !== 1) begin fails++; $display("FAIL basic_sel_fall: got %0d want 1", sel_fall_t[0]); end
    tests++; if (nrise !== 8) begin fails++; $display("FAIL basic_nrise: got %0d want 8", nrise); end
    for (int k = 0; k < 8; k++) begin
      tests++; if (rise_t[k] !== 8 + 8 * k) begin fails++; $display("FAIL basic_rise%0d: got %0d want %0d", k, rise_t[k], 8 + 8 * k); end
      tests++; if (mosi_b[k] !== exp_bits[7-k]) begin fails++; $display("FAIL basic_mosi%0d: got %b want %b", k, mosi_b[k], exp_bits[7-k]); end
    end
    tests++; if (ndone !== 1) begin fails++; $display("FAIL basic_ndone: got %0d want 1", ndone); end
    tests++; if (done_t[0] !== 72) begin fails++; $display("FAIL basic_done_t: got %0d want 72", done_t[0]); end
    tests++; if (done_rx[0] !== 32'h3C) begin fails++; $display("FAIL basic_rx: got %h want 3c", done_rx[0]); end
    tests++; if (sel_rise_t[0] !== 72) begin fails++; $display("FAIL basic_sel_rise: got %0d want 72", sel_rise_t[0]); end
    tests++; if (busy_fall_t !== 76) begin fails++; $display("FAIL basic_busy_fall: got %0d want 76", busy_fall_t); end
    tests++; if (slv_got[0] !== 32'hA5) begin fails++; $display("FAIL basic_slave_rx: got %h want a5", slv_got[0]); end
    tests++; if (mosi8 !== 1'b0) begin fails++; $display("FAIL basic_mosi_idle: got %b want 0", mosi8); end
  endtask

  task automatic test_back_to_back();
    dsel = 2'd0;
    xfer(8, 32'h01, 32'hFF, 32'h81, 32'h7E, 77, -1, 170);
    tests++; if (ndone !== 2) begin fails++; $display("FAIL b2b_ndone: got %0d want 2", ndone); end
    tests++; if (done_t[0] !== 72 || done_t[1] !== 149) begin fails++; $display("FAIL b2b_done_t: got %0d,%0d want 72,149", done_t[0], done_t[1]); end
    tests++; if (done_rx[0] !== 32'h81 || done_rx[1] !== 32'h7E) begin fails++; $display("FAIL b2b_rx: got %h,%h want 81,7e", done_rx[0], done_rx[1]); end
    tests++; if (sel_fall_t[1] - sel_rise_t[0] !== 5) begin fails++; $display("FAIL b2b_sel_gap: got %0d want 5", sel_fall_t[1] - sel_rise_t[0]); end
    tests++; if (slv_got[0] !== 32'h01 || slv_got[1] !== 32'hFF) begin fails++; $display("FAIL b2b_slave_rx: got %h,%h want 01,ff", slv_got[0], slv_got[1]); end
  endtask

  task automatic test_start_ignored();
    dsel = 2'd0;
    xfer(8, 32'hA5, 32'h00, 32'h3C, 32'h3C, 0, 20, 160);
    tests++; if (ndone !== 1) begin fails++; $display("FAIL ign_ndone: got %0d want 1", ndone); end
    tests++; if (nsel_fall !== 1) begin fails++; $display("FAIL ign_nsel: got %0d want 1", nsel_fall); end
    tests++; if (slv_got[0] !== 32'hA5) begin fails++; $display("FAIL ign_slave_rx: got %h want a5", slv_got[0]); end
    tests++; if (done_rx[0] !== 32'h3C) begin fails++; $display("FAIL ign_rx: got %h want 3c", done_rx[0]); end
  endtask

  task automatic test_loopback32();
    dsel = 2'd1;
    xfer(32, 32'hDEADBEEF, 32'hDEADBEEF, 32'h12345678, 32'h12345678, 0, -1, 300);
    tests++; if (done_rx[0] !== 32'h12345678) begin fails++; $display("FAIL w32_rx: got %h want 12345678", done_rx[0]); end
    tests++; if (slv_got[0] !== 32'hDEADBEEF) begin fails++; $display("FAIL w32_slave_rx: got %h want deadbeef", slv_got[0]); end
    tests++; if (done_t[0] !== 264 || ndone !== 1) begin fails++; $display("FAIL w32_done: got t=%0d n=%0d want t=264 n=1", done_t[0], ndone); end
    tests++; if (busy_fall_t !== 268) begin fails++; $display("FAIL w32_busy_fall: got %0d want 268", busy_fall_t); end
  endtask

  task automatic test_min_width();
    dsel = 2'd2;
    xfer(2, 32'h2, 32'h2, 32'h1, 32'h1, 0, -1, 60);
    tests++; if (nrise !== 2) begin fails++; $display("FAIL w2_nrise: got %0d want 2", nrise); end
    tests++; if (rise_t[0] !== 12 || rise_t[1] !== 24) begin fails++; $display("FAIL w2_rise_t: got %0d,%0d want 12,24", rise_t[0], rise_t[1]); end
    tests++; if (mosi_b[0] !== 1'b1 || mosi_b[1] !== 1'b0) begin fails++; $display("FAIL w2_mosi: got %b%b want 10", mosi_b[0], mosi_b[1]); end
    tests++; if (done_t[0] !== 36) begin fails++; $display("FAIL w2_done_t: got %0d want 36", done_t[0]); end
    tests++; if (done_rx[0] !== 32'h1) begin fails++; $display("FAIL w2_rx: got %h want 1", done_rx[0]); end
    tests++; if (busy_fall_t !== 42) begin fails++; $display("FAIL w2_busy_fall: got %0d want 42", busy_fall_t); end
  endtask

  initial begin
    rst = 1'b1;
    miso = 1'b0;
    dsel = 2'd0;
    start8 = 1'b0; start32 = 1'b0; start2 = 1'b0;
    tx8 = '0; tx32 = '0; tx2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_basic8();
    test_back_to_back();
    test_start_ignored();
    test_loopback32();
    test_min_width();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
